// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator with prescaler, edge/center-aligned counting and
// shadowed mode/prescale/duty registers that reload at each period boundary.
module pwm_multi_channel #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [7:0]        wr_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start
);

    typedef enum logic {MODE_EDGE, MODE_CENTER} mode_t;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [NUM_CH-1:0]  oe;
    logic [NUM_CH-1:0]  pol;
    mode_t              mode_stg;
    mode_t              mode_act;
    logic [PRESC_W-1:0] presc_stg;
    logic [PRESC_W-1:0] presc_act;
    logic [CNT_W-1:0]   duty_stg [NUM_CH];
    logic [CNT_W-1:0]   duty_act [NUM_CH];

    logic [PRESC_W-1:0] pcnt;
    logic [CNT_W-1:0]   cnt;
    dir_t               dir;
    logic               tick;
    logic               boundary;
    logic [NUM_CH-1:0]  raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oe        <= '0;
            pol       <= '0;
            mode_stg  <= MODE_EDGE;
            presc_stg <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) duty_stg[i] <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                4'h0:    oe        <= wr_data[NUM_CH-1:0];
                4'h1:    pol       <= wr_data[NUM_CH-1:0];
                4'h2:    mode_stg  <= mode_t'(wr_data[0]);
                4'h3:    presc_stg <= wr_data[PRESC_W-1:0];
                default: begin
                    for (int unsigned i = 0; i < NUM_CH; i++)
                        if (wr_addr == 4'(4 + i)) duty_stg[i] <= wr_data[CNT_W-1:0];
                end
            endcase
        end
    end

    always_comb begin
        tick = (pcnt == presc_act);
        if (mode_act == MODE_EDGE) boundary = tick && (cnt == MAX);
        else                       boundary = tick && (dir == DIR_DOWN) && (cnt == CNT_W'(1));
    end

    // Staging is sampled before this cycle's write lands, so a write coinciding
    // with a boundary waits for the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_act  <= MODE_EDGE;
            presc_act <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) duty_act[i] <= '0;
        end else if (boundary) begin
            mode_act  <= mode_stg;
            presc_act <= presc_stg;
            for (int unsigned i = 0; i < NUM_CH; i++) duty_act[i] <= duty_stg[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            cnt  <= '0;
            dir  <= DIR_UP;
        end else if (boundary) begin
            pcnt <= '0;
            cnt  <= '0;
            dir  <= DIR_UP;
        end else if (tick) begin
            pcnt <= '0;
            if (mode_act == MODE_EDGE) begin
                cnt <= cnt + CNT_W'(1);
            end else if (dir == DIR_UP) begin
                if (cnt == MAX) begin
                    cnt <= MAX - CNT_W'(1);
                    dir <= DIR_DOWN;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end else begin
            pcnt <= pcnt + PRESC_W'(1);
        end
    end

    always_comb begin
        raw = '0;
        for (int unsigned i = 0; i < NUM_CH; i++)
            raw[i] = (cnt < duty_act[i]) || (duty_act[i] == MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out      <= '0;
            period_start <= 1'b0;
        end else begin
            pwm_out      <= oe & (raw ^ pol);
            period_start <= boundary;
        end
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Randomized bench for pwm_multi_channel against a period-position reference model.
module tb_pwm_multi_channel;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 8;
    localparam int PRESC_W = 8;
    localparam int MAXV    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [3:0]        wr_addr = '0;
    logic [7:0]        wr_data = '0;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_start;

    int checks = 0;
    int errors = 0;

    pwm_multi_channel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pwm_out(pwm_out), .period_start(period_start)
    );

    always #5 clk = ~clk;

    // Model: time within the current period plus active/staged settings.
    int m_t, m_mode, m_presc, m_mode_stg, m_presc_stg;
    int m_duty [NUM_CH];
    int m_duty_stg [NUM_CH];
    int m_oe, m_pol;
    int exp_pwm, exp_ps;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_mode = 0; m_presc = 0; m_mode_stg = 0; m_presc_stg = 0;
        m_oe = 0; m_pol = 0; exp_pwm = 0; exp_ps = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_duty[i] = 0;
            m_duty_stg[i] = 0;
        end
    endtask

    function automatic int period_len();
        return (m_mode != 0 ? 2 * MAXV : MAXV + 1) * (m_presc + 1);
    endfunction

    function automatic bit next_is_boundary();
        return m_t == period_len() - 1;
    endfunction

    task automatic model_step();
        int k, c, r;
        bit b;
        k = m_t / (m_presc + 1);
        c = (m_mode == 0) ? k : ((k <= MAXV) ? k : 2 * MAXV - k);
        exp_pwm = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            r = ((c < m_duty[i]) || (m_duty[i] == MAXV)) ? 1 : 0;
            if (m_oe[i]) exp_pwm |= ((r ^ m_pol[i]) & 1) << i;
        end
        b = next_is_boundary();
        exp_ps = b ? 1 : 0;
        if (b) begin
            m_t = 0;
            m_mode = m_mode_stg;
            m_presc = m_presc_stg;
            for (int i = 0; i < NUM_CH; i++) m_duty[i] = m_duty_stg[i];
        end else begin
            m_t++;
        end
        if (wr_en) begin
            if (wr_addr == 0) m_oe = wr_data & ((1 << NUM_CH) - 1);
            else if (wr_addr == 1) m_pol = wr_data & ((1 << NUM_CH) - 1);
            else if (wr_addr == 2) m_mode_stg = wr_data & 1;
            else if (wr_addr == 3) m_presc_stg = wr_data & ((1 << PRESC_W) - 1);
            else if (wr_addr >= 4 && wr_addr < 4 + NUM_CH)
                m_duty_stg[wr_addr - 4] = wr_data & MAXV;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        check_eq("pwm_out", int'(pwm_out), exp_pwm);
        check_eq("period_start", int'(period_start), exp_ps);
        wr_en = 1'b0;
    endtask

    task automatic write_reg(input int a, input int d);
        wr_en = 1'b1;
        wr_addr = 4'(a);
        wr_data = 8'(d);
        cycle();
    endtask

    function automatic int pick_duty();
        case ($urandom_range(0, 4))
            0: return 0;
            1: return MAXV;
            2: return 1;
            3: return MAXV - 1;
            default: return int'($urandom_range(0, MAXV));
        endcase
    endfunction

    initial begin
        int n;
        bit found;
        model_reset();
        repeat (3) cycle();
        rst = 1'b0;

        write_reg(0, 'hF);
        write_reg(4, 'h80);
        repeat (300) cycle();
        rst = 1'b1;
        #1;
        check_eq("rst_async_pwm", int'(pwm_out), 0);
        check_eq("rst_async_ps", int'(period_start), 0);
        repeat (5) cycle();
        rst = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 1000) begin
            n++;
            cycle();
            if (period_start) found = 1'b1;
        end
        check_eq("first_ps_delay", found ? n : -1, 256);

        for (int cyc = 0; cyc < 40000; cyc++) begin
            if (next_is_boundary() && $urandom_range(0, 3) == 0) begin
                write_reg(4 + int'($urandom_range(0, NUM_CH - 1)), pick_duty());
            end else if ($urandom_range(0, 39) == 0) begin
                int a, d;
                a = int'($urandom_range(0, 15));
                if (a == 3) d = int'($urandom_range(0, 3));
                else if (a >= 4) d = pick_duty();
                else d = int'($urandom_range(0, 255));
                write_reg(a, d);
            end else if ($urandom_range(0, 9999) == 0) begin
                rst = 1'b1;
                #1;
                check_eq("rst_async_pwm", int'(pwm_out), 0);
                repeat (2) cycle();
                rst = 1'b0;
            end else begin
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
